// File: rtl/instr_register_pkg.sv
// Shared opcode definitions for the instruction register and its ALU.
// Width-dependent types live in the modules because they follow parameters.
package instr_register_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  function automatic logic is_div_op(input opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU; every operation is carried out at 2*OP_WIDTH so
// no result can overflow (including min / -1).
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  output logic signed [2*OP_WIDTH-1:0] result,
  output logic                         div_zero
);

  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] w_a;
  logic signed [RW-1:0] w_b;
  logic signed [RW-1:0] w_div_b;
  logic                 w_b_zero;

  assign w_a      = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
  assign w_b      = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
  assign w_b_zero = (operand_b == {OP_WIDTH{1'b0}});
  // Divisor is forced to 1 when zero so the divider never sees a zero operand.
  assign w_div_b  = w_b_zero ? RW'(1'b1) : w_b;

  // Operation select
  always_comb begin
    result   = {RW{1'b0}};
    div_zero = 1'b0;
    case (opcode)
      ZERO:  result = {RW{1'b0}};
      PASSA: result = w_a;
      PASSB: result = w_b;
      ADD:   result = w_a + w_b;
      SUB:   result = w_a - w_b;
      MULT:  result = w_a * w_b;
      DIV: begin
        if (w_b_zero) begin
          result   = {RW{1'b0}};
          div_zero = 1'b1;
        end else begin
          result   = w_a / w_div_b;
          div_zero = 1'b0;
        end
      end
      MOD: begin
        if (w_b_zero) begin
          result   = {RW{1'b0}};
          div_zero = 1'b1;
        end else begin
          result   = w_a % w_div_b;
          div_zero = 1'b0;
        end
      end
      default: begin
        result   = {RW{1'b0}};
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_register_param.sv
// DEPTH-entry instruction register: stores opcode/operands plus the ALU result
// computed at write time, with a registered read port and optional auto pointers.
module instr_register_param
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int OP_WIDTH = 32,
  parameter bit AUTO_PTR = 1'b0,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [PW-1:0]                write_pointer,
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  input  logic                         read_en,
  input  logic [PW-1:0]                read_pointer,
  output logic                         rd_valid,
  output logic                         rd_entry_valid,
  output opcode_t                      rd_opcode,
  output logic signed [OP_WIDTH-1:0]   rd_operand_a,
  output logic signed [OP_WIDTH-1:0]   rd_operand_b,
  output logic signed [2*OP_WIDTH-1:0] rd_result,
  output logic                         rd_div_zero,
  output logic [PW:0]                  valid_count
);

  localparam int            RW       = 2 * OP_WIDTH;
  localparam int            PW1      = PW + 1;
  localparam logic [PW:0]   DEPTH_W  = PW1'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  opcode_t                    r_op  [DEPTH];
  logic signed [OP_WIDTH-1:0] r_a   [DEPTH];
  logic signed [OP_WIDTH-1:0] r_b   [DEPTH];
  logic signed [RW-1:0]       r_res [DEPTH];
  logic [DEPTH-1:0]           r_dz;
  logic [DEPTH-1:0]           r_valid;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;

  logic [PW-1:0]        w_wr_addr;
  logic [PW-1:0]        w_rd_addr;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_accept;
  logic signed [RW-1:0] w_alu_result;
  logic                 w_alu_div_zero;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_IDX) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  instr_alu #(
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (w_alu_result),
    .div_zero  (w_alu_div_zero)
  );

  // Address source: internal wrap-around pointers or external addresses
  always_comb begin
    w_wr_addr = write_pointer;
    w_rd_addr = read_pointer;
    if (AUTO_PTR) begin
      w_wr_addr = r_wr_ptr;
      w_rd_addr = r_rd_ptr;
    end else begin
      w_wr_addr = write_pointer;
      w_rd_addr = read_pointer;
    end
  end

  assign w_wr_in_range = ({1'b0, w_wr_addr} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, w_rd_addr} < DEPTH_W);
  assign w_wr_accept   = load_en && w_wr_in_range;

  // Auto pointers advance after each of their own accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (AUTO_PTR && load_en) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (AUTO_PTR && read_en) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
    end
  end

  // Entry storage and valid bits
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]  <= ZERO;
        r_a[i]   <= {OP_WIDTH{1'b0}};
        r_b[i]   <= {OP_WIDTH{1'b0}};
        r_res[i] <= {RW{1'b0}};
      end
      r_dz    <= {DEPTH{1'b0}};
      r_valid <= {DEPTH{1'b0}};
    end else if (w_wr_accept) begin
      r_op[w_wr_addr]    <= opcode;
      r_a[w_wr_addr]     <= operand_a;
      r_b[w_wr_addr]     <= operand_b;
      r_res[w_wr_addr]   <= w_alu_result;
      r_dz[w_wr_addr]    <= w_alu_div_zero;
      r_valid[w_wr_addr] <= 1'b1;
    end
  end

  // Only first writes to an entry grow the count, so it cannot exceed DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_count <= {PW1{1'b0}};
    end else if (w_wr_accept && !r_valid[w_wr_addr]) begin
      valid_count <= valid_count + PW1'(1'b1);
    end
  end

  // Registered read port; sees pre-write contents on a same-cycle collision
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid       <= 1'b0;
      rd_entry_valid <= 1'b0;
      rd_opcode      <= ZERO;
      rd_operand_a   <= {OP_WIDTH{1'b0}};
      rd_operand_b   <= {OP_WIDTH{1'b0}};
      rd_result      <= {RW{1'b0}};
      rd_div_zero    <= 1'b0;
    end else if (read_en) begin
      rd_valid <= 1'b1;
      if (w_rd_in_range) begin
        rd_entry_valid <= r_valid[w_rd_addr];
        rd_opcode      <= r_op[w_rd_addr];
        rd_operand_a   <= r_a[w_rd_addr];
        rd_operand_b   <= r_b[w_rd_addr];
        rd_result      <= r_res[w_rd_addr];
        rd_div_zero    <= r_dz[w_rd_addr];
      end else begin
        rd_entry_valid <= 1'b0;
        rd_opcode      <= ZERO;
        rd_operand_a   <= {OP_WIDTH{1'b0}};
        rd_operand_b   <= {OP_WIDTH{1'b0}};
        rd_result      <= {RW{1'b0}};
        rd_div_zero    <= 1'b0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_register_param.sv
// Bench: three configurations (32x32 manual, 6x8 manual, 4x16 auto-pointer)
// driven with directed and random traffic, checked against an array-based model.
module tb_instr_register_param;
  import instr_register_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // per-configuration parameters: index 0 = 32x32 manual, 1 = 6x8 manual, 2 = 4x16 auto
  int P_D [3] = '{32, 6, 4};
  int P_W [3] = '{32, 8, 16};
  bit P_AUTO [3] = '{1'b0, 1'b0, 1'b1};

  // stimulus
  logic    in_load [3];
  logic    in_rd   [3];
  int      in_wp   [3];
  int      in_rp   [3];
  opcode_t in_op   [3];
  longint  in_a    [3];
  longint  in_b    [3];

  // reference model state
  bit      m_v   [3][32];
  opcode_t m_op  [3][32];
  longint  m_a   [3][32];
  longint  m_b   [3][32];
  int      m_cnt [3];
  int      m_wp  [3];
  int      m_rp  [3];

  // expected read-port contents
  logic    e_rv  [3];
  logic    e_ev  [3];
  logic    e_dz  [3];
  opcode_t e_op  [3];
  longint  e_a   [3];
  longint  e_b   [3];
  longint  e_res [3];

  logic        d0_rv, d0_ev, d0_dz;
  opcode_t     d0_op;
  logic [31:0] d0_a, d0_b;
  logic [63:0] d0_res;
  logic [5:0]  d0_cnt;

  logic        d1_rv, d1_ev, d1_dz;
  opcode_t     d1_op;
  logic [7:0]  d1_a, d1_b;
  logic [15:0] d1_res;
  logic [3:0]  d1_cnt;

  logic        d2_rv, d2_ev, d2_dz;
  opcode_t     d2_op;
  logic [15:0] d2_a, d2_b;
  logic [31:0] d2_res;
  logic [2:0]  d2_cnt;

  instr_register_param #(.DEPTH(32), .OP_WIDTH(32), .AUTO_PTR(1'b0)) u_dut0 (
    .clk(clk), .reset(rst), .load_en(in_load[0]), .write_pointer(in_wp[0][4:0]),
    .opcode(in_op[0]), .operand_a(in_a[0][31:0]), .operand_b(in_b[0][31:0]),
    .read_en(in_rd[0]), .read_pointer(in_rp[0][4:0]),
    .rd_valid(d0_rv), .rd_entry_valid(d0_ev), .rd_opcode(d0_op),
    .rd_operand_a(d0_a), .rd_operand_b(d0_b), .rd_result(d0_res),
    .rd_div_zero(d0_dz), .valid_count(d0_cnt)
  );

  instr_register_param #(.DEPTH(6), .OP_WIDTH(8), .AUTO_PTR(1'b0)) u_dut1 (
    .clk(clk), .reset(rst), .load_en(in_load[1]), .write_pointer(in_wp[1][2:0]),
    .opcode(in_op[1]), .operand_a(in_a[1][7:0]), .operand_b(in_b[1][7:0]),
    .read_en(in_rd[1]), .read_pointer(in_rp[1][2:0]),
    .rd_valid(d1_rv), .rd_entry_valid(d1_ev), .rd_opcode(d1_op),
    .rd_operand_a(d1_a), .rd_operand_b(d1_b), .rd_result(d1_res),
    .rd_div_zero(d1_dz), .valid_count(d1_cnt)
  );

  instr_register_param #(.DEPTH(4), .OP_WIDTH(16), .AUTO_PTR(1'b1)) u_dut2 (
    .clk(clk), .reset(rst), .load_en(in_load[2]), .write_pointer(in_wp[2][1:0]),
    .opcode(in_op[2]), .operand_a(in_a[2][15:0]), .operand_b(in_b[2][15:0]),
    .read_en(in_rd[2]), .read_pointer(in_rp[2][1:0]),
    .rd_valid(d2_rv), .rd_entry_valid(d2_ev), .rd_opcode(d2_op),
    .rd_operand_a(d2_a), .rd_operand_b(d2_b), .rd_result(d2_res),
    .rd_div_zero(d2_dz), .valid_count(d2_cnt)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Signed reference arithmetic straight from the operation table (64-bit is wide enough).
  function automatic longint alu_ref(input opcode_t op, input longint a, input longint b);
    case (op)
      ZERO:    return 0;
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     return (b == 0) ? 0 : a / b;
      MOD:     return (b == 0) ? 0 : a % b;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(input int k);
    int addr;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_v[k][i] = 1'b0; m_op[k][i] = ZERO; m_a[k][i] = 0; m_b[k][i] = 0;
      end
      m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
      e_rv[k] = 1'b0; e_ev[k] = 1'b0; e_dz[k] = 1'b0; e_op[k] = ZERO;
      e_a[k] = 0; e_b[k] = 0; e_res[k] = 0;
      return;
    end
    if (in_rd[k]) begin
      addr = P_AUTO[k] ? m_rp[k] : in_rp[k];
      e_rv[k] = 1'b1;
      if (addr < P_D[k]) begin
        e_ev[k]  = m_v[k][addr];
        e_op[k]  = m_op[k][addr];
        e_a[k]   = m_a[k][addr];
        e_b[k]   = m_b[k][addr];
        e_res[k] = alu_ref(m_op[k][addr], m_a[k][addr], m_b[k][addr]);
        e_dz[k]  = (m_op[k][addr] == DIV || m_op[k][addr] == MOD) && (m_b[k][addr] == 0);
      end else begin
        e_ev[k] = 1'b0; e_op[k] = ZERO; e_a[k] = 0; e_b[k] = 0; e_res[k] = 0; e_dz[k] = 1'b0;
      end
      if (P_AUTO[k]) m_rp[k] = (m_rp[k] + 1) % P_D[k];
    end else begin
      e_rv[k] = 1'b0;
    end
    if (in_load[k]) begin
      addr = P_AUTO[k] ? m_wp[k] : in_wp[k];
      if (addr < P_D[k]) begin
        if (!m_v[k][addr]) m_cnt[k]++;
        m_v[k][addr]  = 1'b1;
        m_op[k][addr] = in_op[k];
        m_a[k][addr]  = in_a[k];
        m_b[k][addr]  = in_b[k];
      end
      if (P_AUTO[k]) m_wp[k] = (m_wp[k] + 1) % P_D[k];
    end
  endfunction

  task automatic cmp_all(input int k, input logic rv, input logic ev, input logic [2:0] op,
                         input logic signed [63:0] a, input logic signed [63:0] b,
                         input logic signed [63:0] res, input logic dz, input logic [7:0] cnt);
    check_eq($sformatf("u%0d.rd_valid", k), rv, e_rv[k]);
    check_eq($sformatf("u%0d.rd_entry_valid", k), ev, e_ev[k]);
    check_eq($sformatf("u%0d.rd_opcode", k), op, e_op[k]);
    check_eq($sformatf("u%0d.rd_operand_a", k), a, e_a[k]);
    check_eq($sformatf("u%0d.rd_operand_b", k), b, e_b[k]);
    check_eq($sformatf("u%0d.rd_result", k), res, e_res[k]);
    check_eq($sformatf("u%0d.rd_div_zero", k), dz, e_dz[k]);
    check_eq($sformatf("u%0d.valid_count", k), cnt, m_cnt[k]);
  endtask

  // One clock: model follows the sampled inputs, then every output is compared.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model_step(k);
    cmp_all(0, d0_rv, d0_ev, d0_op, $signed(d0_a), $signed(d0_b), $signed(d0_res), d0_dz, 8'(d0_cnt));
    cmp_all(1, d1_rv, d1_ev, d1_op, $signed(d1_a), $signed(d1_b), $signed(d1_res), d1_dz, 8'(d1_cnt));
    cmp_all(2, d2_rv, d2_ev, d2_op, $signed(d2_a), $signed(d2_b), $signed(d2_res), d2_dz, 8'(d2_cnt));
  endtask

  task automatic clear_in();
    for (int k = 0; k < 3; k++) begin
      in_load[k] = 1'b0; in_rd[k] = 1'b0; in_wp[k] = 0; in_rp[k] = 0;
      in_op[k] = ZERO; in_a[k] = 0; in_b[k] = 0;
    end
  endtask

  task automatic set_wr(input int k, input int ptr, input opcode_t op, input longint a, input longint b);
    in_load[k] = 1'b1; in_wp[k] = ptr; in_op[k] = op; in_a[k] = a; in_b[k] = b;
  endtask

  task automatic set_rd(input int k, input int ptr);
    in_rd[k] = 1'b1; in_rp[k] = ptr;
  endtask

  function automatic longint rnd_val(input int w);
    longint v;
    v = longint'({$urandom(), $urandom()});
    case ($urandom_range(0, 5))
      0:       v = 0;
      1:       v = -1;
      2:       v = -(longint'(1) <<< (w - 1));
      3:       v = (longint'(1) <<< (w - 1)) - 1;
      default: v = v;
    endcase
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Fresh read of entry 0
    set_rd(0, 0); tick(); clear_in();
    check_eq("reset_rd_valid", d0_rv, 1'b1);
    check_eq("reset_entry_valid", d0_ev, 1'b0);
    check_eq("reset_result", $signed(d0_res), 0);
    check_eq("reset_count", d0_cnt, 0);

    // MULT into entry 5, then overwrite it
    set_wr(0, 5, MULT, -3, 7); tick(); clear_in();
    check_eq("mult_count", d0_cnt, 1);
    set_rd(0, 5); tick(); clear_in();
    check_eq("mult_result", $signed(d0_res), -21);
    check_eq("mult_entry_valid", d0_ev, 1'b1);
    set_wr(0, 5, ADD, 1, 1); tick(); clear_in();
    check_eq("overwrite_count", d0_cnt, 1);

    // Division corner cases
    set_wr(0, 6, DIV, 7, 0); tick(); clear_in();
    set_wr(0, 7, DIV, -7, 2); set_rd(0, 6); tick(); clear_in();
    check_eq("div0_result", $signed(d0_res), 0);
    check_eq("div0_flag", d0_dz, 1'b1);
    set_wr(0, 8, MOD, -7, 2); set_rd(0, 7); tick(); clear_in();
    check_eq("div_neg_result", $signed(d0_res), -3);
    check_eq("div_neg_flag", d0_dz, 1'b0);
    set_rd(0, 8); tick(); clear_in();
    check_eq("mod_neg_result", $signed(d0_res), -1);

    // 8-bit extremes and out-of-range addressing on the 6-entry instance
    set_wr(1, 0, SUB, -128, 127); tick(); clear_in();
    set_wr(1, 1, DIV, -128, -1); set_rd(1, 0); tick(); clear_in();
    check_eq("sub8_result", $signed(d1_res), -255);
    set_wr(1, 7, ADD, 5, 5); set_rd(1, 1); tick(); clear_in();
    check_eq("div8_min_result", $signed(d1_res), 128);
    check_eq("oor_write_count", d1_cnt, 2);
    set_rd(1, 6); tick(); clear_in();
    check_eq("oor_rd_valid", d1_rv, 1'b1);
    check_eq("oor_entry_valid", d1_ev, 1'b0);

    // Auto pointer wrap on the 4-entry instance
    for (int i = 0; i < 5; i++) begin
      set_wr(2, 0, ADD, 10 * i, 1); tick(); clear_in();
    end
    check_eq("auto_count", d2_cnt, 4);
    for (int i = 0; i < 5; i++) begin
      longint exp_res [5] = '{41, 11, 21, 31, 41};
      set_rd(2, 0); tick(); clear_in();
      check_eq($sformatf("auto_read%0d", i), $signed(d2_res), exp_res[i]);
    end

    // Same-cycle read/write of entry 3 returns the old data
    set_wr(0, 3, ADD, 2, 3); tick(); clear_in();
    set_wr(0, 3, SUB, 10, 4); set_rd(0, 3); tick(); clear_in();
    check_eq("rbw_old_result", $signed(d0_res), 5);
    set_rd(0, 3); tick(); clear_in();
    check_eq("rbw_new_result", $signed(d0_res), 6);

    // Reset overrides a concurrent write
    set_wr(0, 9, ADD, 1, 2); set_rd(0, 3); rst = 1'b1; tick(); clear_in(); rst = 1'b0;
    check_eq("rst_rd_valid", d0_rv, 1'b0);
    check_eq("rst_result", $signed(d0_res), 0);
    check_eq("rst_count", d0_cnt, 0);
    set_rd(0, 9); tick(); clear_in();
    check_eq("rst_no_write", d0_ev, 1'b0);

    // Random traffic on all three instances
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        in_load[k] = ($urandom_range(0, 2) != 0);
        in_rd[k]   = ($urandom_range(0, 2) != 0);
        in_wp[k]   = (k == 1) ? $urandom_range(0, 7) : $urandom_range(0, P_D[k] - 1);
        in_rp[k]   = (k == 1) ? $urandom_range(0, 7) : $urandom_range(0, P_D[k] - 1);
        in_op[k]   = opcode_t'($urandom_range(0, 7));
        in_a[k]    = rnd_val(P_W[k]);
        in_b[k]    = rnd_val(P_W[k]);
      end
      tick();
    end
    rst = 1'b0;
    clear_in();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
